// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data; optional sticky overflow/underflow under PARAM_SYNC_FIFO_ERR_FLAGS_EN.
// Read data and rd_valid appear one cycle after an accepted read; writes while full (no read) and reads while empty are dropped.
module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc = wr && (!full || rd);
  assign rd_acc = rd && !empty;

  assign full         = (fifo_cnt == CW'(DEPTH));
  assign empty        = (fifo_cnt == '0);
  assign almost_full  = (fifo_cnt >= CW'(AF_LEVEL));
  assign almost_empty = (fifo_cnt <= CW'(AE_LEVEL));

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Old contents are read even when wr_ptr == rd_ptr, so full read+write returns the oldest word.
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) begin
        overflow <= 1'b1;
      end
      if (rd && empty && !wr) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: default 8x16 instance plus a 32x4 instance with custom thresholds.
module tb_param_sync_fifo;

  logic        clk;
  int          errors = 0;
  int          checks = 0;

  // Default instance
  logic        rst, wr, rd;
  logic [7:0]  din, dout;
  logic        rv, full, empty, af, ae;
  logic [4:0]  cnt;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  logic        ovf, unf;
`endif

  // 32-bit, depth-4 instance
  logic        rst_b, wr_b, rd_b;
  logic [31:0] din_b, dout_b;
  logic        rv_b, full_b, empty_b, af_b, ae_b;
  logic [2:0]  cnt_b;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  logic        ovf_b, unf_b;
`endif

  param_sync_fifo dut_a (
    .clk(clk), .rst(rst), .wr(wr), .data_in(din), .rd(rd),
    .data_out(dout), .rd_valid(rv), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .fifo_cnt(cnt)
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf), .underflow(unf)
`endif
  );

  param_sync_fifo #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rst(rst_b), .wr(wr_b), .data_in(din_b), .rd(rd_b),
    .data_out(dout_b), .rd_valid(rv_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .fifo_cnt(cnt_b)
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf_b), .underflow(unf_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic cyc_b(input logic w, input logic r, input logic [31:0] d);
    wr_b  = w;
    rd_b  = r;
    din_b = d;
    @(posedge clk);
    #1;
    wr_b  = 1'b0;
    rd_b  = 1'b0;
  endtask

  // Flag model for the default instance: AF at 14, AE at 2, full at 16.
  task automatic flags_a(input string tag, input int n);
    check({tag, ".cnt"},   32'(cnt),   32'(n));
    check({tag, ".full"},  32'(full),  32'(n == 16));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".af"},    32'(af),    32'(n >= 14));
    check({tag, ".ae"},    32'(ae),    32'(n <= 2));
  endtask

  logic [7:0]  q[$];
  logic [7:0]  exp_d;
  logic [31:0] vec_b[4];
  logic        w_k, r_k;
  int          n;

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    rst_b = 1'b1; wr_b = 1'b0; rd_b = 1'b0; din_b = '0;
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0; rst_b = 1'b0;

    // Reset state
    flags_a("reset", 0);
    check("reset.rv",   32'(rv),   32'h0);
    check("reset.dout", 32'(dout), 32'h0);
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    check("reset.ovf", 32'(ovf), 32'h0);
    check("reset.unf", 32'(unf), 32'h0);
`endif

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      flags_a($sformatf("fill%0d", i), i + 1);
      check($sformatf("fill%0d.rv", i), 32'(rv), 32'h0);
    end

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d.dout", i), 32'(dout), 32'(i));
      check($sformatf("drain%0d.rv", i),   32'(rv),   32'h1);
      check($sformatf("drain%0d.cnt", i),  32'(cnt),  32'(15 - i));
    end
    cyc(1'b0, 1'b0, 8'h00);
    check("idle.rv",   32'(rv),   32'h0);
    check("idle.dout", 32'(dout), 32'h0F);
    flags_a("idle", 0);

    // Read while empty is dropped
    cyc(1'b0, 1'b1, 8'h00);
    check("under.rv",   32'(rv),   32'h0);
    check("under.dout", 32'(dout), 32'h0F);
    check("under.cnt",  32'(cnt),  32'h0);
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    check("under.unf", 32'(unf), 32'h1);
    check("under.ovf", 32'(ovf), 32'h0);
`endif

    // Empty with simultaneous read/write: write only, no fall-through
    cyc(1'b1, 1'b1, 8'hA5);
    check("erw.cnt",  32'(cnt),  32'h1);
    check("erw.rv",   32'(rv),   32'h0);
    check("erw.dout", 32'(dout), 32'h0F);
    cyc(1'b0, 1'b1, 8'h00);
    check("erw_rd.dout", 32'(dout), 32'hA5);
    check("erw_rd.rv",   32'(rv),   32'h1);
    check("erw_rd.cnt",  32'(cnt),  32'h0);

    // Full with simultaneous read/write returns the oldest word
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
    flags_a("refill", 16);
    cyc(1'b1, 1'b1, 8'h55);
    check("frw.dout", 32'(dout), 32'h00);
    check("frw.rv",   32'(rv),   32'h1);
    flags_a("frw", 16);

    // Write while full is dropped
    cyc(1'b1, 1'b0, 8'hFF);
    check("over.rv",   32'(rv),   32'h0);
    check("over.dout", 32'(dout), 32'h00);
    flags_a("over", 16);
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    check("over.ovf", 32'(ovf), 32'h1);
`endif

    for (int i = 1; i < 17; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check($sformatf("fdrain%0d.dout", i), 32'(dout), (i == 16) ? 32'h55 : 32'(i));
      check($sformatf("fdrain%0d.rv", i),   32'(rv),   32'h1);
    end
    flags_a("fdrain_end", 0);

    // Mixed traffic across pointer wrap, occupancy held within 3..9
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 8'(32'h20 + i));
      q.push_back(8'(32'h20 + i));
      n++;
    end
    for (int k = 0; k < 40; k++) begin
      w_k = (k % 3) != 2;
      r_k = (k % 4) != 0;
      if (n <= 3) r_k = 1'b0;
      if (n >= 9) w_k = 1'b0;
      cyc(w_k, r_k, 8'(32'h40 + k));
      if (r_k) begin
        exp_d = q.pop_front();
        check($sformatf("mix%0d.dout", k), 32'(dout), 32'(exp_d));
      end
      check($sformatf("mix%0d.rv", k), 32'(rv), 32'(r_k));
      if (w_k) q.push_back(8'(32'h40 + k));
      n = n + int'(w_k) - int'(r_k);
      check($sformatf("mix%0d.cnt", k), 32'(cnt), 32'(n));
    end

    // Reset wins over a concurrent write
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'hEE);
    rst = 1'b0;
    flags_a("rstwr", 0);
    check("rstwr.rv",   32'(rv),   32'h0);
    check("rstwr.dout", 32'(dout), 32'h0);
    cyc(1'b0, 1'b1, 8'h00);
    check("rstwr_rd.rv",   32'(rv),   32'h0);
    check("rstwr_rd.dout", 32'(dout), 32'h0);
    check("rstwr_rd.cnt",  32'(cnt),  32'h0);

    // 32-bit, depth-4 instance: AF at >=3, AE at <=1
    vec_b[0] = 32'hDEADBEEF;
    vec_b[1] = 32'h12345678;
    vec_b[2] = 32'hA5A55A5A;
    vec_b[3] = 32'h0F0FF0F0;
    check("b_reset.cnt", 32'(cnt_b), 32'h0);
    check("b_reset.ae",  32'(ae_b),  32'h1);
    check("b_reset.af",  32'(af_b),  32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc_b(1'b1, 1'b0, vec_b[i]);
      check($sformatf("bw%0d.cnt", i),  32'(cnt_b),  32'(i + 1));
      check($sformatf("bw%0d.af", i),   32'(af_b),   32'((i + 1) >= 3));
      check($sformatf("bw%0d.ae", i),   32'(ae_b),   32'((i + 1) <= 1));
      check($sformatf("bw%0d.full", i), 32'(full_b), 32'((i + 1) == 4));
    end
    for (int i = 0; i < 4; i++) begin
      cyc_b(1'b0, 1'b1, 32'h0);
      check($sformatf("br%0d.dout", i), dout_b, vec_b[i]);
      check($sformatf("br%0d.rv", i),   32'(rv_b), 32'h1);
      check($sformatf("br%0d.ae", i),   32'(ae_b), 32'((3 - i) <= 1));
      check($sformatf("br%0d.af", i),   32'(af_b), 32'((3 - i) >= 3));
    end
    check("b_end.empty", 32'(empty_b), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits; legal range 1..256.
REQ-002 Parameter DEPTH, default 16: number of entries; power of two; legal range 2..1024.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold in entries; legal range 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 2: almost-empty threshold in entries; legal range 1..DEPTH-1.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous and active-high.
REQ-007 Port wr, input, 1: write request.
REQ-008 Port data_in, input, DATA_W: write data, sampled when a write is accepted.
REQ-009 Port rd, input, 1: read request.
REQ-010 Port data_out, output, DATA_W: registered read data.
REQ-011 Port rd_valid, output, 1: high for one cycle when data_out was updated by an accepted read.
REQ-012 Port full / empty, output, 1 each: count==DEPTH / count==0.
REQ-013 Port almost_full / almost_empty, output, 1 each: count>=AF_LEVEL / count<=AE_LEVEL.
REQ-014 Port fifo_cnt, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.

Function
REQ-015 The write is accepted only when wr=1 and (full=0 or rd=1); an accepted write stores data_in at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-016 The read is accepted only when rd=1 and empty=0; an accepted read loads data_out from rd_ptr at the same edge, asserts rd_valid at the next cycle (1-cycle latency), and rd_ptr increments modulo DEPTH.
REQ-017 When empty=1 and rd=wr=1, the write is accepted, the read is ignored, fifo_cnt becomes 1 and rd_valid stays 0; no fall-through.
REQ-018 When full=1 and rd=wr=1, both are accepted and fifo_cnt stays DEPTH; the read returns the oldest word, never the word written in that cycle.
REQ-019 fifo_cnt: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-020 A write while full (rd=0) and a read while empty are dropped: no state change and data_out held.
REQ-021 data_out holds its last value when no read is accepted.
REQ-022 Pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without a gap.
REQ-023 All flags are combinational decodes of registered fifo_cnt and are valid in the cycle after the updating edge.

Reset
REQ-024 When rst=1 at a clock edge, the block clears wr_ptr, rd_ptr and fifo_cnt to 0, data_out to 0 and rd_valid to 0, and the result is empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-025 rst has priority over wr/rd in the same cycle; storage contents are not reset; a reset mid-operation discards all held words.

Configuration
REQ-026 Macro PARAM_SYNC_FIFO_ERR_FLAGS_EN, when defined, adds sticky outputs overflow and underflow, 1 bit each; each is cleared by rst only.
REQ-027 With the macro defined, overflow sets at the edge where a write is dropped per REQ-020, and underflow sets at the edge where a read is dropped per REQ-020.
REQ-028 Without the macro, overflow and underflow ports and logic are absent, and all other behaviour is identical.

Verification
REQ-029 Defaults: after reset, write 16 words 0x00..0x0F -> full=1 and fifo_cnt=16, and almost_full was first high at fifo_cnt=14; then read 16 words -> data_out 0x00..0x0F in order, each with rd_valid one cycle after rd, ending with empty=1.
REQ-030 Empty, rd=wr=1 with data_in=0xA5 -> fifo_cnt=1, rd_valid=0; the next read returns 0xA5.
REQ-031 Full with 0x00..0x0F, rd=wr=1 with data_in=0x55 -> data_out=0x00, fifo_cnt=16; draining returns 0x01..0x0F, then 0x55.
REQ-032 Full with wr=1 and data_in=0xFF -> fifo_cnt=16 and contents unchanged, and with the macro defined overflow=1; empty with rd=1 -> data_out held, rd_valid=0, and with the macro defined underflow=1.
REQ-033 Wrap: 40 cycles of mixed traffic keeping fifo_cnt between 3 and 9 -> output sequence matches a scoreboard; then rst=1 together with wr=1 -> fifo_cnt=0, empty=1, and the write is discarded.
REQ-034 DATA_W=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 -> almost_full high at fifo_cnt>=3, almost_empty high at fifo_cnt<=1, and 32-bit data is intact.
